mat_stream_loader: RTL and testbench
====================================

MAT_STREAM_LOADER -- requirements
Module: mat_stream_loader

Interface
REQ-001 Parameter: N, 5, matrix order (rows = columns).
REQ-002 Parameter: W, 32, element width in bits, two's complement.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: clr  input  1  synchronous abort of the current load.
REQ-006 Port: in_data  input  W  one matrix element, row-major order (a11, a12 ... a15, a21 ... a55).
REQ-007 Port: in_valid  input  1  in_data is valid this cycle.
REQ-008 Port: in_ready  output  1  block accepts an element this cycle.
REQ-009 Port: mat_out  output  N*N*W  full matrix; element (r,c), 1-based, at bits [W*(N*(r-1)+(c-1)) +: W].
REQ-010 Port: mat_valid  output  1  mat_out holds a complete matrix for the downstream inverter.
REQ-011 Port: mat_ack  input  1  downstream has consumed mat_out.
REQ-012 Port: elem_cnt  output  5  number of elements accepted in the current load, 0..N*N.

Function
REQ-013 Two states: LOAD (in_ready=1, mat_valid=0) and HOLD (in_ready=0, mat_valid=1); outputs are decoded from state only.
REQ-014 Transfer occurs on a cycle with in_valid=1 and in_ready=1; in_data is then written to element (row, col) and elem_cnt increments by 1.
REQ-015 Row/col counters: col increments per transfer; at col=N it wraps to 1 and row increments; after (N,N) both wrap to (1,1).
REQ-016 The transfer writing element (N,N) moves LOAD->HOLD; mat_valid is 1 on the next cycle (latency 1 cycle from the last transfer).
REQ-017 in_valid while in_ready=0 is ignored; no element is written and counters do not change.
REQ-018 In HOLD, mat_out, elem_cnt (=N*N) and mat_valid stay stable until mat_ack=1.
REQ-019 mat_ack=1 in HOLD moves HOLD->LOAD; the next cycle has mat_valid=0, in_ready=1, elem_cnt=0, and row/col=(1,1).
REQ-020 mat_ack in LOAD is ignored.
REQ-021 After an ack, mat_out keeps the previous matrix contents; each element is overwritten only when its new value is transferred.
REQ-022 Elements are stored bit-exact; no sign extension, saturation or reordering.
REQ-023 clr=1 forces the next state to LOAD with elem_cnt=0, row/col=(1,1) and all mat_out elements set to 0, whether the block is in LOAD or HOLD.
REQ-024 clr has priority over a simultaneous transfer or mat_ack; that element is discarded.
REQ-025 Throughput: one element per cycle when in_valid is held high; a full matrix takes N*N cycles plus 1 cycle to HOLD.

Reset
REQ-026 rst=1 immediately, without waiting for clk, forces LOAD, elem_cnt=0, row/col=(1,1), mat_out=0, mat_valid=0, in_ready=1.
REQ-027 rst asserted mid-load or in HOLD discards all partial or complete data; the first accepted element after release is element (1,1).

Verification
REQ-028 Load 25 elements back-to-back: 5,3,1,7,9 / 6,4,2,8,-8 / 7,5,3,10,9 / 9,6,4,-9,-5 / 8,5,2,11,4.
  Required response: mat_valid=1 exactly 1 cycle after the 25th transfer, element (2,5)=0xFFFFFFF8, element (4,4)=0xFFFFFFF7, elem_cnt=25.
REQ-029 Same data with in_valid toggling 1,0,1,0.
  Required response: only the 25 valid cycles are accepted, the matrix is identical to REQ-028, and elem_cnt steps only on transfers.
REQ-030 In HOLD, drive in_valid=1 with data 0x12345678 for 10 cycles, then assert mat_ack.
  Required response: mat_out is unchanged throughout; on the cycle after ack, mat_valid=0 and in_ready=1; the next element lands at (1,1).
REQ-031 Assert clr after 12 elements, simultaneously with in_valid=1.
  Required response: elem_cnt=0 and mat_out=0 on the next cycle, and the clr-cycle element is discarded.
REQ-032 Assert rst asynchronously between clock edges after 24 elements.
  Required response: outputs go to their reset values immediately (mat_valid=0, elem_cnt=0); a following 25-element load completes normally.
REQ-033 Hold mat_ack=1 continuously while loading two consecutive matrices.
  Required response: each HOLD lasts exactly 1 cycle, and mat_ack has no effect in LOAD.

Source files
------------

// File: rtl/mat_stream_loader.sv
// Collects an N x N matrix streamed element by element in row-major order
// and holds it for a downstream consumer until acknowledged.
module mat_stream_loader #(
  parameter int N = 5,
  parameter int W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [W-1:0]     in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [N*N*W-1:0] mat_out,
  output logic             mat_valid,
  input  logic             mat_ack,
  output logic [4:0]       elem_cnt
);

  localparam int CW = $clog2(N + 1);
  localparam int IW = $clog2(N * N);

  typedef enum logic {
    S_LOAD,
    S_HOLD
  } state_t;

  state_t          r_state;
  state_t          w_state_n;
  logic [CW-1:0]   r_row;
  logic [CW-1:0]   r_col;
  logic [4:0]      r_cnt;
  logic [W-1:0]    r_mat [N*N];
  logic [IW-1:0]   w_idx;
  logic            w_xfer;
  logic            w_last;

  assign w_last = (r_row == CW'(N)) && (r_col == CW'(N));
  assign w_idx  = IW'(N * (int'(r_row) - 1) + int'(r_col) - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_LOAD;
    end else begin
      r_state <= w_state_n;
    end
  end

  // clr overrides any transfer or ack in the same cycle
  always_comb begin
    w_state_n = r_state;
    w_xfer    = 1'b0;
    if (clr) begin
      w_state_n = S_LOAD;
    end else begin
      unique case (r_state)
        S_LOAD: begin
          if (in_valid) begin
            w_xfer = 1'b1;
            if (w_last) begin
              w_state_n = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (mat_ack) begin
            w_state_n = S_LOAD;
          end
        end
        default: w_state_n = S_LOAD;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row <= CW'(1);
      r_col <= CW'(1);
      r_cnt <= '0;
      for (int i = 0; i < N * N; i++) begin
        r_mat[i] <= '0;
      end
    end else if (clr) begin
      r_row <= CW'(1);
      r_col <= CW'(1);
      r_cnt <= '0;
      for (int i = 0; i < N * N; i++) begin
        r_mat[i] <= '0;
      end
    end else if (w_xfer) begin
      r_mat[w_idx] <= in_data;
      r_cnt        <= r_cnt + 5'd1;
      if (r_col == CW'(N)) begin
        r_col <= CW'(1);
        r_row <= (r_row == CW'(N)) ? CW'(1) : r_row + CW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end else if (r_state == S_HOLD && mat_ack) begin
      r_cnt <= '0;
    end
  end

  genvar g;
  generate
    for (g = 0; g < N * N; g++) begin : g_out
      assign mat_out[g*W +: W] = r_mat[g];
    end
  endgenerate

  assign in_ready  = (r_state == S_LOAD);
  assign mat_valid = (r_state == S_HOLD);
  assign elem_cnt  = r_cnt;

endmodule

// File: tb/tb_mat_stream_loader.sv
// Directed and randomized checks of mat_stream_loader against a
// matrix-level reference model.
module tb_mat_stream_loader;

  localparam int N  = 5;
  localparam int W  = 32;
  localparam int NN = N * N;
  localparam int MW = N * N * W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clr = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [MW-1:0] mat_out;
  logic          mat_valid;
  logic          mat_ack = 1'b0;
  logic [4:0]    elem_cnt;

  int nchk = 0;
  int nerr = 0;

  logic [W-1:0] em [NN];
  int           ecnt;
  bit           ehold;
  int           nmats;

  int fixed_d [NN] = '{5, 3, 1, 7, 9,
                       6, 4, 2, 8, -8,
                       7, 5, 3, 10, 9,
                       9, 6, 4, -9, -5,
                       8, 5, 2, 11, 4};

  mat_stream_loader #(.N(N), .W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mat_out  (mat_out),
    .mat_valid(mat_valid),
    .mat_ack  (mat_ack),
    .elem_cnt (elem_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [MW-1:0] exp_mat();
    logic [MW-1:0] m;
    m = '0;
    for (int i = 0; i < NN; i++) m[i*W +: W] = em[i];
    return m;
  endfunction

  task automatic mdl_clear();
    for (int i = 0; i < NN; i++) em[i] = '0;
    ecnt  = 0;
    ehold = 0;
  endtask

  task automatic chk(string tag, logic [MW-1:0] obs, logic [MW-1:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(string tag);
    chk({tag, ".mat"}, mat_out, exp_mat());
    chk({tag, ".cnt"}, MW'(elem_cnt), MW'(ecnt));
    chk({tag, ".valid"}, MW'(mat_valid), MW'(ehold));
    chk({tag, ".ready"}, MW'(in_ready), MW'(!ehold));
  endtask

  // one clock; model consumes the inputs that were present at the edge
  task automatic step(string tag);
    bit           v = in_valid;
    bit           a = mat_ack;
    bit           c = clr;
    logic [W-1:0] d = in_data;
    @(posedge clk);
    #1;
    if (c) begin
      mdl_clear();
    end else if (!ehold && v) begin
      em[ecnt] = d;
      ecnt++;
      if (ecnt == NN) begin
        ehold = 1;
        nmats++;
      end
    end else if (ehold && a) begin
      ehold = 0;
      ecnt  = 0;
    end
    chk_all(tag);
  endtask

  task automatic load_rand(int n, string tag);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      step(tag);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    int guard;
    mdl_clear();
    nmats = 0;
    #1;
    chk_all("reset");
    #11;
    rst = 1'b0;

    // back-to-back fixed matrix
    for (int i = 0; i < NN; i++) begin
      in_valid = 1'b1;
      in_data  = fixed_d[i];
      step("b2b");
    end
    in_valid = 1'b0;
    chk("b2b.e25", MW'(mat_out[W*(N*1+4) +: W]), MW'(32'hFFFF_FFF8));
    chk("b2b.e44", MW'(mat_out[W*(N*3+3) +: W]), MW'(32'hFFFF_FFF7));
    chk("b2b.hold", MW'(mat_valid), MW'(1'b1));
    mat_ack = 1'b1;
    step("ack1");
    mat_ack = 1'b0;

    // same data with in_valid toggling, garbage on idle cycles
    for (int i = 0; i < 2 * NN; i++) begin
      in_valid = (i % 2 == 0);
      in_data  = (i % 2 == 0) ? fixed_d[i/2] : $urandom;
      step("toggle");
    end
    in_valid = 1'b0;
    chk("toggle.e25", MW'(mat_out[W*(N*1+4) +: W]), MW'(32'hFFFF_FFF8));

    // data offered while holding must be ignored
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h1234_5678;
      step("holdign");
    end
    in_valid = 1'b0;
    mat_ack  = 1'b1;
    step("ack2");
    mat_ack = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'hA5A5_0001;
    step("first");
    in_valid = 1'b0;
    chk("first.e11", MW'(mat_out[W-1:0]), MW'(32'hA5A5_0001));

    // clr after 12 elements, colliding with a transfer
    load_rand(11, "pre_clr");
    in_valid = 1'b1;
    in_data  = $urandom;
    clr      = 1'b1;
    step("clr");
    clr      = 1'b0;
    in_valid = 1'b0;
    chk("clr.zero", mat_out, '0);

    // asynchronous reset between edges after 24 elements
    load_rand(24, "pre_rst");
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    mdl_clear();
    chk_all("arst");
    @(negedge clk);
    rst = 1'b0;
    load_rand(NN, "post_rst");
    mat_ack = 1'b1;
    step("ack3");

    // ack held high across two loads with random gaps
    nmats = 0;
    guard = 0;
    while (nmats < 2 && guard < 400) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = $urandom;
      step("ackhi");
      guard++;
    end
    chk("ackhi.mats", MW'(nmats), MW'(2));
    in_valid = 1'b0;
    step("ackhi.end");

    // fully random traffic
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = $urandom;
      mat_ack  = ($urandom_range(0, 3) == 0);
      clr      = ($urandom_range(0, 63) == 0);
      step("rand");
    end
    clr      = 1'b0;
    mat_ack  = 1'b0;
    in_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end

endmodule
